pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller that sequences pc_reg and the IF/ID and ID/EX pipeline registers. It merges redirect requests from the execute stage and the interrupt controller with hold requests from execute (multi-cycle ops), the bus arbiter and the debug port. It produces a single jump/hold pair for pc_reg plus a flush strobe for the pipeline registers. Redirects that arrive while the pipeline is frozen are buffered and issued on release, never dropped.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_o stays high per redirect (pipeline depth behind PC); legal range 1..7
ADDR_W, 32, instruction address width (matches InstAddrBus)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
jump_flag_ex_i  input  1  execute-stage branch/jump taken
jump_addr_ex_i  input  ADDR_W  execute-stage target
int_assert_i  input  1  interrupt/trap redirect request (one-cycle pulse)
int_addr_i  input  ADDR_W  trap vector
hold_ex_i  input  1  execute multi-cycle stall
hold_bus_i  input  1  bus arbiter stall
halt_jtag_i  input  1  debug halt request (level)
jump_flag_o  output  1  to pc_reg jump_flag_i
jump_addr_o  output  ADDR_W  to pc_reg jump_addr_i
hold_flag_o  output  1  to pc_reg hold_flag_i and IF/ID, ID/EX hold
flush_o  output  1  clear IF/ID and ID/EX to NOP
halted_o  output  1  core halted for debug
pend_valid_o  output  1  a buffered redirect is waiting (status)

Behaviour:
- Reset (rst low, async): state RUN, pend_valid=0, pend_addr=0, flush counter=0. All outputs forced to 0 while rst low.
- held = hold_ex_i | hold_bus_i | (state==HALT).
- States: RUN, FLUSH, HALT.
- Redirect source priority: int_assert_i > pending > jump_flag_ex_i.
- RUN, not held, source present: jump_flag_o=1 and jump_addr_o=source address, combinationally in the same cycle. flush_o=1 in the same cycle. If the source was pending, clear pend_valid. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; else stay in RUN.
- RUN, not held, no source: all outputs 0 except the status outputs.
- Any state, held: hold_flag_o=1, jump_flag_o=0, flush_o=0.
  - An arriving int is latched into pend (overwrites any pending ex jump).
  - An arriving ex jump is latched only if pend_valid=0.
  - The FLUSH counter freezes while held.
- FLUSH: flush_o=1 each unheld cycle; counter decrements and returns to RUN when it reaches 1→0. jump_flag_ex_i is ignored (wrong-path). int_assert_i is accepted and issued immediately: jump_flag_o=1, counter reloaded to FLUSH_CYCLES-1.
- HALT:
  - Entered from any state on the cycle after halt_jtag_i is sampled high; an active FLUSH completes first.
  - halted_o=1 and hold_flag_o=1 throughout.
  - Exit to RUN on the cycle after halt_jtag_i is sampled low. A pending redirect is issued in the first RUN cycle.
- Simultaneous events:
  - int + ex jump in the same unheld cycle: int is issued and the ex jump is discarded.
  - Hold release + pending + new ex jump: the pending redirect is issued and the ex jump is discarded (it is wrong-path after the redirect).
- pend_addr width is ADDR_W; no arithmetic is performed on addresses.
- Reset mid-FLUSH or mid-HALT: immediate return to the reset state; pending is lost.

Decomposition:
- Shared defines: state encodings (RUN=2'd0, FLUSH=2'd1, HALT=2'd2), the existing JumpEnable/HoldEnable/Rst constants, and the reset flush count.
- Sub-module redirect_buf: single-entry pending-redirect register with priority overwrite (inputs: set_int, set_ex, int_addr, ex_addr, clr; outputs: valid, addr). The remainder stays in pipe_ctrl.

Test Plan:
- Reset, then a single ex jump to 0x100 with no holds → jump_flag_o=1 and jump_addr_o=0x100 in the same cycle; flush_o high for exactly 2 cycles; pc_reg shows 0x100.
- hold_bus_i high for 3 cycles, ex jump to 0x200 pulsed in cycle 1 → jump_flag_o=0 and pend_valid_o=1 while held; first cycle after release jump_flag_o=1, jump_addr_o=0x200, pend cleared.
- Held, ex jump 0x300 then int to 0x80 → after release jump_addr_o=0x80; 0x300 never issued.
- Int 0x80 on the second FLUSH cycle of an ex redirect → immediate jump to 0x80; flush_o extends 2 cycles from the int; an ex jump during FLUSH is ignored.
- halt_jtag_i high for 5 cycles → halted_o=1 and hold_flag_o=1 from the next cycle until 1 cycle after deassertion; PC is unchanged throughout.
- rst low asynchronously mid-FLUSH with a pending redirect → all outputs 0 immediately; after rst high no jump is issued and the PC starts at the reset address.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and control constants for the pipeline controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;
  localparam logic       JumpEnable = 1'b1;
  localparam logic       HoldEnable = 1'b1;
  localparam logic       RstEnable  = 1'b0;
  localparam logic [2:0] FlushRst   = 3'd0;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: redirect/hold request inputs and pc_reg/pipeline-register control outputs.
//   ctrl modport   : controller side (requests in, jump/hold/flush/status out)
//   master modport : requester / pc_reg side
interface pipe_ctrl_if #(parameter int ADDR_W = 32);
  logic              jump_flag_ex_i;
  logic [ADDR_W-1:0] jump_addr_ex_i;
  logic              int_assert_i;
  logic [ADDR_W-1:0] int_addr_i;
  logic              hold_ex_i;
  logic              hold_bus_i;
  logic              halt_jtag_i;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              hold_flag_o;
  logic              flush_o;
  logic              halted_o;
  logic              pend_valid_o;
  modport ctrl (
    input  jump_flag_ex_i, jump_addr_ex_i, int_assert_i, int_addr_i,
           hold_ex_i, hold_bus_i, halt_jtag_i,
    output jump_flag_o, jump_addr_o, hold_flag_o, flush_o, halted_o, pend_valid_o
  );
  modport master (
    output jump_flag_ex_i, jump_addr_ex_i, int_assert_i, int_addr_i,
           hold_ex_i, hold_bus_i, halt_jtag_i,
    input  jump_flag_o, jump_addr_o, hold_flag_o, flush_o, halted_o, pend_valid_o
  );
endinterface

// File: rtl/pipe_ctrl_redirect_buf.sv
// pipe_ctrl_redirect_buf: single-entry pending redirect; an int overwrites, an ex jump only fills an empty slot.
//   clk, rst (async active-low), set_int/set_ex with their addresses, clr -> valid, addr
module pipe_ctrl_redirect_buf
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_int,
  input  logic              set_ex,
  input  logic              clr,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  assign valid = r_valid;
  assign addr  = r_addr;
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (set_int) begin
      r_valid <= 1'b1;
      r_addr  <= int_addr;
    end else if (set_ex && !r_valid) begin
      r_valid <= 1'b1;
      r_addr  <= ex_addr;
    end else if (clr) begin
      r_valid <= 1'b0;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges redirect and hold requests into one jump/hold pair for pc_reg plus a pipeline flush strobe.
//   clk, rst (async active-low), p (pipe_ctrl_if.ctrl): ex/int redirects, ex/bus/debug holds in;
//   jump_flag/addr, hold_flag, flush, halted, pend_valid out
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.ctrl  p
);
  localparam logic [2:0] Reload = 3'(FLUSH_CYCLES - 1);
  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              w_held;
  logic              w_ex;
  logic              w_src;
  logic              w_issue;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_addr;
  logic [ADDR_W-1:0] w_src_addr;
  assign w_held     = p.hold_ex_i | p.hold_bus_i | (r_state == HALT);
  // ex jumps seen during FLUSH are wrong-path and never captured or issued
  assign w_ex       = p.jump_flag_ex_i & (r_state != FLUSH);
  assign w_src      = p.int_assert_i | w_pend_valid | w_ex;
  assign w_src_addr = p.int_assert_i ? p.int_addr_i : w_pend_valid ? w_pend_addr : p.jump_addr_ex_i;
  // HALT is always held, so issue only happens in RUN or FLUSH
  assign w_issue    = (rst != RstEnable) & ~w_held & w_src;
  assign p.jump_flag_o  = w_issue ? JumpEnable : ~JumpEnable;
  assign p.jump_addr_o  = w_issue ? w_src_addr : '0;
  assign p.hold_flag_o  = ((rst != RstEnable) & w_held) ? HoldEnable : ~HoldEnable;
  assign p.flush_o      = (rst != RstEnable) & ~w_held & (w_issue | (r_state == FLUSH));
  assign p.halted_o     = r_state == HALT;
  assign p.pend_valid_o = w_pend_valid;
  // any issued redirect supersedes whatever is buffered, so clear on every issue
  pipe_ctrl_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .set_int  (p.int_assert_i & w_held),
    .set_ex   (w_ex & w_held),
    .clr      (w_issue),
    .int_addr (p.int_addr_i),
    .ex_addr  (p.jump_addr_ex_i),
    .valid    (w_pend_valid),
    .addr     (w_pend_addr)
  );
  // a running flush always completes before a debug halt is honoured
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      r_state <= RUN;
      r_cnt   <= FlushRst;
    end else if (w_issue) begin
      r_state <= (Reload != 3'd0) ? FLUSH : p.halt_jtag_i ? HALT : RUN;
      r_cnt   <= Reload;
    end else if (r_state == FLUSH) begin
      if (!w_held) begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) r_state <= p.halt_jtag_i ? HALT : RUN;
      end
    end else begin
      r_state <= p.halt_jtag_i ? HALT : RUN;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, directed corner sequences and a randomized run against a reference model.
module tb_pipe_ctrl;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] pc;
  logic [31:0] pc_hold;
  pipe_ctrl_if #(.ADDR_W(32)) bus ();
  pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) pc <= 32'h0;
    else if (bus.jump_flag_o) pc <= bus.jump_addr_o;
    else if (!bus.hold_flag_o) pc <= pc + 32'd4;

  typedef struct {
    logic        jf;
    logic [31:0] ja;
    logic        ia;
    logic [31:0] iad;
    logic        hex;
    logic        hbus;
    logic        e_jump;
    logic [31:0] e_addr;
    logic        e_hold;
    logic        e_flush;
    logic        e_pend;
  } vec_t;
  vec_t tbl [7];

  bit          m_halt;
  int          m_left;
  logic [31:0] m_pend [$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic jf, input logic [31:0] ja, input logic ia, input logic [31:0] iad,
                       input logic hex, input logic hbus, input logic hlt);
    bus.jump_flag_ex_i = jf;
    bus.jump_addr_ex_i = ja;
    bus.int_assert_i   = ia;
    bus.int_addr_i     = iad;
    bus.hold_ex_i      = hex;
    bus.hold_bus_i     = hbus;
    bus.halt_jtag_i    = hlt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    rst = 1'b1;
    m_halt = 1'b0;
    m_left = 0;
    m_pend.delete();
  endtask

  // Expected outputs follow directly from the redirect/hold rules: held cycles buffer,
  // free cycles issue the best source, a redirect opens a window of FC flush cycles.
  task automatic model_check();
    logic held, e_jump, e_hold, e_flush, e_pv, e_halted, found;
    logic [31:0] e_addr;
    held = bus.hold_ex_i | bus.hold_bus_i | m_halt;
    e_jump = 1'b0; e_addr = 32'h0; e_hold = 1'b0; e_flush = 1'b0; found = 1'b0;
    e_pv = m_pend.size() != 0;
    e_halted = m_halt;
    if (held) begin
      e_hold = 1'b1;
      if (bus.int_assert_i) begin
        m_pend.delete();
        m_pend.push_back(bus.int_addr_i);
      end else if (bus.jump_flag_ex_i && m_left == 0 && m_pend.size() == 0) begin
        m_pend.push_back(bus.jump_addr_ex_i);
      end
    end else begin
      if (bus.int_assert_i) begin found = 1'b1; e_addr = bus.int_addr_i; end
      else if (m_pend.size() != 0) begin found = 1'b1; e_addr = m_pend[0]; end
      else if (bus.jump_flag_ex_i && m_left == 0) begin found = 1'b1; e_addr = bus.jump_addr_ex_i; end
      if (found) begin
        e_jump = 1'b1;
        e_flush = 1'b1;
        m_pend.delete();
        m_left = FC - 1;
      end else if (m_left > 0) begin
        e_flush = 1'b1;
        m_left--;
      end
    end
    if (m_left == 0) m_halt = bus.halt_jtag_i;
    chk("rnd_jump", {31'b0, bus.jump_flag_o}, {31'b0, e_jump});
    chk("rnd_addr", bus.jump_addr_o, e_addr);
    chk("rnd_hold", {31'b0, bus.hold_flag_o}, {31'b0, e_hold});
    chk("rnd_flush", {31'b0, bus.flush_o}, {31'b0, e_flush});
    chk("rnd_halted", {31'b0, bus.halted_o}, {31'b0, e_halted});
    chk("rnd_pend", {31'b0, bus.pend_valid_o}, {31'b0, e_pv});
  endtask

  initial begin
    logic hlt;
    tbl[0] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h0,   1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h200, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    idle();
    chk("rst_jump", {31'b0, bus.jump_flag_o}, 32'h0);
    chk("rst_halted", {31'b0, bus.halted_o}, 32'h0);
    chk("rst_pend", {31'b0, bus.pend_valid_o}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      drive(tbl[i].jf, tbl[i].ja, tbl[i].ia, tbl[i].iad, tbl[i].hex, tbl[i].hbus, 1'b0);
      chk($sformatf("v%0d_jump", i), {31'b0, bus.jump_flag_o}, {31'b0, tbl[i].e_jump});
      chk($sformatf("v%0d_addr", i), bus.jump_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_hold", i), {31'b0, bus.hold_flag_o}, {31'b0, tbl[i].e_hold});
      chk($sformatf("v%0d_flush", i), {31'b0, bus.flush_o}, {31'b0, tbl[i].e_flush});
      step();
      idle();
      chk($sformatf("v%0d_pend", i), {31'b0, bus.pend_valid_o}, {31'b0, tbl[i].e_pend});
    end
    // single ex jump: two flush cycles, PC follows
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("a_jump", {31'b0, bus.jump_flag_o}, 32'h1);
    chk("a_addr", bus.jump_addr_o, 32'h100);
    chk("a_flush0", {31'b0, bus.flush_o}, 32'h1);
    step();
    idle();
    chk("a_flush1", {31'b0, bus.flush_o}, 32'h1);
    chk("a_pc", pc, 32'h100);
    step();
    chk("a_flush2", {31'b0, bus.flush_o}, 32'h0);
    // ex jump buffered under bus hold, issued on release
    do_reset();
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("b_jump_held", {31'b0, bus.jump_flag_o}, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("b_pend", {31'b0, bus.pend_valid_o}, 32'h1);
    chk("b_hold", {31'b0, bus.hold_flag_o}, 32'h1);
    step();
    step();
    idle();
    chk("b_rel_jump", {31'b0, bus.jump_flag_o}, 32'h1);
    chk("b_rel_addr", bus.jump_addr_o, 32'h200);
    step();
    chk("b_pend_clr", {31'b0, bus.pend_valid_o}, 32'h0);
    // int overwrites a buffered ex jump
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    chk("c_addr", bus.jump_addr_o, 32'h80);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("c_no_stale", {31'b0, bus.jump_flag_o}, 32'h0);
    end
    // int during FLUSH restarts the flush window; ex jumps in FLUSH are dropped
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h500, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("d_int_jump", {31'b0, bus.jump_flag_o}, 32'h1);
    chk("d_int_addr", bus.jump_addr_o, 32'h80);
    step();
    drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("d_ex_ignored", {31'b0, bus.jump_flag_o}, 32'h0);
    chk("d_flush_ext", {31'b0, bus.flush_o}, 32'h1);
    step();
    idle();
    chk("d_flush_end", {31'b0, bus.flush_o}, 32'h0);
    chk("d_no_jump", {31'b0, bus.jump_flag_o}, 32'h0);
    // debug halt for five cycles
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("e_halt_c0", {31'b0, bus.halted_o}, 32'h0);
    step();
    pc_hold = pc;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, k < 5);
      chk($sformatf("e_halted_c%0d", k), {31'b0, bus.halted_o}, 32'h1);
      chk($sformatf("e_hold_c%0d", k), {31'b0, bus.hold_flag_o}, 32'h1);
      step();
    end
    idle();
    chk("e_pc_frozen", pc, pc_hold);
    chk("e_halt_exit", {31'b0, bus.halted_o}, 32'h0);
    chk("e_hold_exit", {31'b0, bus.hold_flag_o}, 32'h0);
    // async reset mid-FLUSH with a buffered int
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
    step();
    chk("f_pend", {31'b0, bus.pend_valid_o}, 32'h1);
    rst = 1'b0;
    #1;
    chk("f_rst_jump", {31'b0, bus.jump_flag_o}, 32'h0);
    chk("f_rst_addr", bus.jump_addr_o, 32'h0);
    chk("f_rst_flush", {31'b0, bus.flush_o}, 32'h0);
    chk("f_rst_hold", {31'b0, bus.hold_flag_o}, 32'h0);
    chk("f_rst_halted", {31'b0, bus.halted_o}, 32'h0);
    chk("f_rst_pend", {31'b0, bus.pend_valid_o}, 32'h0);
    step();
    rst = 1'b1;
    idle();
    chk("f_after_jump", {31'b0, bus.jump_flag_o}, 32'h0);
    chk("f_after_pc", pc, 32'h0);
    // randomized run against the reference model
    do_reset();
    hlt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) hlt = ~hlt;
      drive($urandom_range(0, 9) < 3, {$urandom_range(0, 16'hffff), 2'b00} & 32'h3ffff,
            $urandom_range(0, 9) == 0, {$urandom_range(0, 255), 2'b00} & 32'h3ff,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, hlt);
      model_check();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
